// File: rtl/cmul_pkg.sv
// cmul_pkg: shared constants and state encoding for the complex multiply controller
package cmul_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int RES_W = 2 * WIDTH_DEF + 1;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_M0   = 3'd1,
    S_M1   = 3'd2,
    S_M2   = 3'd3,
    S_M3   = 3'd4,
    S_DONE = 3'd5
  } state_e;
  function automatic int res_width(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/cmul_shared_mult.sv
// cmul_shared_mult: combinational signed multiplier, full-width product
module cmul_shared_mult #(
  parameter int W = 5
) (
  input  logic signed [W-1:0]   x_i,
  input  logic signed [W-1:0]   y_i,
  output logic signed [2*W-1:0] p_o
);
  assign p_o = $signed({{W{x_i[W-1]}}, x_i} * {{W{y_i[W-1]}}, y_i});
endmodule

// File: rtl/complex_mult_ctrl.sv
// complex_mult_ctrl: sequential complex multiply on one shared multiplier.
// Define CMUL_GAUSS3_EN for the 3-multiply schedule; default is the 4-multiply schedule.
module complex_mult_ctrl
  import cmul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   a_re,
  input  logic signed [WIDTH-1:0]   a_im,
  input  logic signed [WIDTH-1:0]   b_re,
  input  logic signed [WIDTH-1:0]   b_im,
  output logic                      busy,
  output logic                      done,
  output logic signed [2*WIDTH:0]   res_re,
  output logic signed [2*WIDTH:0]   res_im,
  output logic                      sel_x,
  output logic                      sel_y
);
  localparam int RW = res_width(WIDTH);
  localparam int MW = WIDTH + 1;
  localparam int AW = 2 * MW;
`ifdef CMUL_GAUSS3_EN
  localparam state_e LAST = S_M2;
`else
  localparam state_e LAST = S_M3;
`endif
  state_e state_q, state_d;
  logic signed [WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
  logic signed [MW-1:0] ar, ai, br, bi, x, y;
  logic signed [AW-1:0] p, acc_re_q, acc_im_q, acc_re_d, acc_im_d;
  logic signed [RW-1:0] res_re_q, res_im_q;
  logic busy_q, done_q, sel_x_q, sel_y_q, sx_d, sy_d, accept;
  assign ar = {ar_q[WIDTH-1], ar_q};
  assign ai = {ai_q[WIDTH-1], ai_q};
  assign br = {br_q[WIDTH-1], br_q};
  assign bi = {bi_q[WIDTH-1], bi_q};
  assign accept = (state_q == S_IDLE) && start;
  cmul_shared_mult #(.W(MW)) u_mult (.x_i(x), .y_i(y), .p_o(p));
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_M0 : S_IDLE;
      S_M0:    state_d = S_M1;
      S_M1:    state_d = S_M2;
      S_M2:    state_d = (LAST == S_M2) ? S_DONE : S_M3;
      S_M3:    state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
`ifdef CMUL_GAUSS3_EN
  // k1 feeds both accumulators, k2 only the imaginary one, k3 is removed from the real one
  always_comb begin
    x = (state_q == S_M0) ? ar + ai : (state_q == S_M1) ? ar : ai;
    y = (state_q == S_M0) ? br : (state_q == S_M1) ? bi - br : br + bi;
    acc_re_d = (state_q == S_M0) ? acc_re_q + p : (state_q == S_M2) ? acc_re_q - p : acc_re_q;
    acc_im_d = (state_q == S_M0 || state_q == S_M1) ? acc_im_q + p : acc_im_q;
    sx_d = state_d == S_M2;
    sy_d = state_d == S_M1 || state_d == S_M2;
  end
`else
  always_comb begin
    x = (state_q == S_M0 || state_q == S_M2) ? ar : ai;
    y = (state_q == S_M0 || state_q == S_M3) ? br : bi;
    acc_re_d = (state_q == S_M0) ? acc_re_q + p : (state_q == S_M1) ? acc_re_q - p : acc_re_q;
    acc_im_d = (state_q == S_M2 || state_q == S_M3) ? acc_im_q + p : acc_im_q;
    sx_d = state_d == S_M1 || state_d == S_M3;
    sy_d = state_d == S_M1 || state_d == S_M2;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ar_q     <= '0;
      ai_q     <= '0;
      br_q     <= '0;
      bi_q     <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sel_x_q  <= 1'b0;
      sel_y_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= state_d != S_IDLE;
      done_q   <= state_d == S_DONE;
      sel_x_q  <= sx_d;
      sel_y_q  <= sy_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      if (accept) begin
        ar_q     <= a_re;
        ai_q     <= a_im;
        br_q     <= b_re;
        bi_q     <= b_im;
        acc_re_q <= '0;
        acc_im_q <= '0;
      end
      // final sums always fit RW bits even though intermediates may not
      if (state_q == LAST) begin
        res_re_q <= acc_re_d[RW-1:0];
        res_im_q <= acc_im_d[RW-1:0];
      end
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign res_re = res_re_q;
  assign res_im = res_im_q;
  assign sel_x  = sel_x_q;
  assign sel_y  = sel_y_q;
endmodule

// File: tb/tb_complex_mult_ctrl.sv
// tb_complex_mult_ctrl: timeline model of the multiply controller plus directed vectors
module tb_complex_mult_ctrl;
  import cmul_pkg::*;
`ifdef CMUL_GAUSS3_EN
  localparam int NM = 3;
  logic [3:0] sx_tab = 4'b0100;
  logic [3:0] sy_tab = 4'b0110;
`else
  localparam int NM = 4;
  logic [3:0] sx_tab = 4'b1010;
  logic [3:0] sy_tab = 4'b0110;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic signed [3:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  logic busy, done, sel_x, sel_y;
  logic signed [RES_W-1:0] res_re, res_im;
  int n_cmp = 0, n_err = 0;
  int cyc = 0, acc_cyc = -1000, ph = 0;
  int p_re = 0, p_im = 0, m_re = 0, m_im = 0;
  bit armed = 1'b0;

  complex_mult_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .busy(busy), .done(done), .res_re(res_re), .res_im(res_im),
    .sel_x(sel_x), .sel_y(sel_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // model: an operation is a timeline anchored at the accepting edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      acc_cyc <= -1000;
      m_re <= 0;
      m_im <= 0;
      armed <= 1'b1;
    end else if (cyc - acc_cyc > NM && start) begin
      acc_cyc <= cyc + 1;
      p_re <= int'(a_re) * int'(b_re) - int'(a_im) * int'(b_im);
      p_im <= int'(a_re) * int'(b_im) + int'(a_im) * int'(b_re);
    end else if (cyc + 1 - acc_cyc == NM) begin
      m_re <= p_re;
      m_im <= p_im;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      ph = cyc - acc_cyc;
      chk("busy", {31'b0, busy}, {31'b0, ph <= NM});
      chk("done", {31'b0, done}, {31'b0, ph == NM});
      chk("sel_x", {31'b0, sel_x}, {31'b0, (ph < NM) ? sx_tab[ph[1:0]] : 1'b0});
      chk("sel_y", {31'b0, sel_y}, {31'b0, (ph < NM) ? sy_tab[ph[1:0]] : 1'b0});
      chk("res_re", {23'b0, res_re}, {23'b0, m_re[8:0]});
      chk("res_im", {23'b0, res_im}, {23'b0, m_im[8:0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int ar, ai, br, bi, ere, eim, input bit scramble, input string tag);
    int got;
    int v;
    got = 0;
    a_re = 4'(ar); a_im = 4'(ai); b_re = 4'(br); b_im = 4'(bi);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy_first"}, {31'b0, busy}, 32'd1);
    for (int n = 1; n <= 10 && got == 0; n++) begin
      tick();
      if (scramble && n == 1) begin
        v = int'($urandom);
        a_re = v[3:0]; a_im = v[7:4]; b_re = v[11:8]; b_im = v[15:12];
      end
      if (done) got = n;
    end
    // accepting edge counts as edge 1
    chk({tag, " done_edge"}, got + 1, NM + 1);
    chk({tag, " re"}, {23'b0, res_re}, 32'(ere) & 32'h1ff);
    chk({tag, " im"}, {23'b0, res_im}, 32'(eim) & 32'h1ff);
    tick();
    chk({tag, " idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int last, cnt;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset res_re", {23'b0, res_re}, 32'd0);
    run_op(3, 2, 1, 4, -5, 14, 1'b0, "v1");
    run_op(-8, -8, -8, -8, 0, 128, 1'b0, "v2");
    run_op(-8, 7, -8, -8, 120, 8, 1'b0, "v3");
    run_op(3, 2, 1, 4, -5, 14, 1'b1, "scramble");
    run_op(-8, 7, -8, -8, 120, 8, 1'b1, "scramble2");
    // continuous start: one accept per full pass, DONE cycle ignores start
    a_re = 4'sd1; a_im = 4'sd1; b_re = 4'sd1; b_im = 4'sd1;
    start = 1'b1;
    last = -1;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done) begin
        if (last >= 0) chk("done_period", n - last, NM + 2);
        chk("cont re", {23'b0, res_re}, 32'd0);
        chk("cont im", {23'b0, res_im}, 32'd2);
        last = n;
        cnt++;
      end
    end
    start = 1'b0;
    chk("cont done_count", cnt >= 5, 32'd1);
    repeat (NM + 2) tick();
    // reset mid-operation
    a_re = 4'sd3; a_im = 4'sd2; b_re = 4'sd1; b_im = 4'sd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    chk("abort res_re", {23'b0, res_re}, 32'd0);
    chk("abort res_im", {23'b0, res_im}, 32'd0);
    chk("abort sel", {30'b0, sel_x, sel_y}, 32'd0);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (done) cnt++;
    end
    chk("abort no_done", cnt, 32'd0);
    run_op(-8, 7, -8, -8, 120, 8, 1'b0, "after_abort");
    // rst wins over start
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_prio busy", {31'b0, busy}, 32'd0);
    tick();
    chk("rst_prio busy2", {31'b0, busy}, 32'd0);
    run_op(1, 1, 1, 1, 0, 2, 1'b0, "final");
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
